// File: rtl/amm_slave_responder.sv
// rtl/amm_slave_responder.sv - Avalon-MM slave memory model with queued fixed-latency read bursts
// Optional LFSR waitrequest stall injection: define AMM_RESP_WAIT_INJECT_EN
module amm_slave_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int AMM_BURST_W = 4,
    parameter int RD_LATENCY  = 4,
    parameter int RD_Q_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADDR_W-1:0]      address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [AMM_BURST_W-1:0] burstcount_i,
    input  logic [DATA_W/8-1:0]    byteenable_i,
    input  logic [DATA_W-1:0]      writedata_i,
    output logic                   waitrequest_o,
    output logic [DATA_W-1:0]      readdata_o,
    output logic                   readdatavalid_o,
    output logic                   busy_o,
    output logic                   proto_err_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(RD_Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {W_IDLE, W_BURST} wr_state_e;
    typedef enum logic {R_IDLE, R_BURST} rd_state_e;

    logic [DATA_W-1:0]      mem     [2**ADDR_W];
    logic [ADDR_W-1:0]      q_addr  [RD_Q_DEPTH];
    logic [AMM_BURST_W-1:0] q_cnt   [RD_Q_DEPTH];
    logic [15:0]            q_stamp [RD_Q_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       q_count_q, q_count_d;
    logic [15:0]            now_q, now_d;
    wr_state_e              wr_state_q, wr_state_d;
    logic [ADDR_W-1:0]      wr_base_q, wr_base_d;
    logic [AMM_BURST_W-1:0] wr_n_q, wr_n_d, wr_cnt_q, wr_cnt_d;
    rd_state_e              rd_state_q, rd_state_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [AMM_BURST_W-1:0] rd_left_q, rd_left_d;
    logic [DATA_W-1:0]      readdata_q, readdata_d;
    logic                   rdvalid_q, rdvalid_d;
    logic                   proto_err_q, proto_err_d;

    logic                   stall, q_full, q_empty, rd_acc, wr_acc, pop, emit, head_ready;
    logic [AMM_BURST_W-1:0] bc_eff;
    logic [ADDR_W-1:0]      wr_addr, emit_addr;
    logic [DATA_W-1:0]      rd_word;

`ifdef AMM_RESP_WAIT_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    assign q_full  = (q_count_q == CNT_W'(RD_Q_DEPTH));
    assign q_empty = (q_count_q == '0);
    assign bc_eff  = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;

    assign waitrequest_o = rst_i | stall |
                           (read_i & (write_i | q_full | (wr_state_q == W_BURST)));
    assign rd_acc  = read_i & ~waitrequest_o;
    assign wr_acc  = write_i & ~waitrequest_o;
    assign wr_addr = (wr_state_q == W_IDLE) ? address_i : wr_base_q + ADDR_W'(wr_n_q);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_base_d  = wr_base_q;
        wr_n_d     = wr_n_q;
        wr_cnt_d   = wr_cnt_q;
        if (wr_acc) begin
            if (wr_state_q == W_IDLE) begin
                if (bc_eff > AMM_BURST_W'(1)) begin
                    wr_state_d = W_BURST;
                    wr_base_d  = address_i;
                    wr_n_d     = AMM_BURST_W'(1);
                    wr_cnt_d   = bc_eff;
                end
            end else if (wr_n_q == wr_cnt_q - AMM_BURST_W'(1)) begin
                wr_state_d = W_IDLE;
            end else begin
                wr_n_d = wr_n_q + AMM_BURST_W'(1);
            end
        end
    end

    // Stamp is the counter value after the accepting edge, so the first beat lands RD_LATENCY edges later.
    assign head_ready = !q_empty && ((now_q - q_stamp[rd_ptr_q]) >= 16'(RD_LATENCY - 1));

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_left_d  = rd_left_q;
        emit       = 1'b0;
        pop        = 1'b0;
        emit_addr  = rd_addr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (head_ready) begin
                    emit      = 1'b1;
                    emit_addr = q_addr[rd_ptr_q];
                    if (q_cnt[rd_ptr_q] <= AMM_BURST_W'(1)) begin
                        pop = 1'b1;
                    end else begin
                        rd_state_d = R_BURST;
                        rd_addr_d  = q_addr[rd_ptr_q] + ADDR_W'(1);
                        rd_left_d  = q_cnt[rd_ptr_q] - AMM_BURST_W'(1);
                    end
                end
            end
            R_BURST: begin
                emit      = 1'b1;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                rd_left_d = rd_left_q - AMM_BURST_W'(1);
                if (rd_left_q == AMM_BURST_W'(1)) begin
                    pop        = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Forward bytes written at the same edge so an emitted beat never returns stale data.
    always_comb begin
        rd_word = mem[emit_addr];
        if (wr_acc && (wr_addr == emit_addr)) begin
            for (int k = 0; k < BE_W; k++) begin
                if (byteenable_i[k]) rd_word[k*8 +: 8] = writedata_i[k*8 +: 8];
            end
        end
        rdvalid_d  = emit;
        readdata_d = emit ? rd_word : readdata_q;
    end

    always_comb begin
        now_d       = now_q + 16'd1;
        wr_ptr_d    = wr_ptr_q + PTR_W'(rd_acc);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        q_count_d   = q_count_q + CNT_W'(rd_acc) - CNT_W'(pop);
        proto_err_d = proto_err_q | (read_i & write_i) |
                      ((rd_acc | (wr_acc & (wr_state_q == W_IDLE))) & (burstcount_i == '0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            q_count_q   <= '0;
            now_q       <= '0;
            wr_state_q  <= W_IDLE;
            wr_base_q   <= '0;
            wr_n_q      <= '0;
            wr_cnt_q    <= '0;
            rd_state_q  <= R_IDLE;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            readdata_q  <= '0;
            rdvalid_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            q_count_q   <= q_count_d;
            now_q       <= now_d;
            wr_state_q  <= wr_state_d;
            wr_base_q   <= wr_base_d;
            wr_n_q      <= wr_n_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_state_q  <= rd_state_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            readdata_q  <= readdata_d;
            rdvalid_q   <= rdvalid_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int k = 0; k < BE_W; k++) begin
                if (byteenable_i[k]) mem[wr_addr][k*8 +: 8] <= writedata_i[k*8 +: 8];
            end
        end
        if (rd_acc) begin
            q_addr[wr_ptr_q]  <= address_i;
            q_cnt[wr_ptr_q]   <= bc_eff;
            q_stamp[wr_ptr_q] <= now_d;
        end
    end

    assign readdata_o      = readdata_q;
    assign readdatavalid_o = rdvalid_q;
    assign proto_err_o     = proto_err_q;
    assign busy_o          = !q_empty | (rd_state_q == R_BURST) | (wr_state_q == W_BURST);
endmodule

// File: tb/tb_amm_slave_responder.sv
// tb/tb_amm_slave_responder.sv - directed scoreboard bench for amm_slave_responder
module tb_amm_slave_responder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [9:0]  address_i;
    logic        read_i, write_i;
    logic [3:0]  burstcount_i;
    logic [7:0]  byteenable_i;
    logic [63:0] writedata_i;
    logic        waitrequest_o, readdatavalid_o, busy_o, proto_err_o;
    logic [63:0] readdata_o;

    typedef struct {
        logic [63:0] data;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [1024];
    int          edge_cnt = 0;
    int          last_edge = -1000;
    int          n_cmp = 0;
    int          n_err = 0;
    int          t1, t2, t3, t4, t5, t;

    amm_slave_responder dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .address_i      (address_i),
        .read_i         (read_i),
        .write_i        (write_i),
        .burstcount_i   (burstcount_i),
        .byteenable_i   (byteenable_i),
        .writedata_i    (writedata_i),
        .waitrequest_o  (waitrequest_o),
        .readdata_o     (readdata_o),
        .readdatavalid_o(readdatavalid_o),
        .busy_o         (busy_o),
        .proto_err_o    (proto_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (readdatavalid_o === 1'b1) begin
            chk("beat_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_data", readdata_o, e.data);
                chk("beat_cycle", edge_cnt, e.edge_no + 1);
            end
        end
    end

    task automatic wr(input int drv_addr, input int bc, input int m_addr,
                      input logic [7:0] be, input logic [63:0] d);
        bit acc;
        acc = 0;
        @(negedge clk);
        write_i = 1; address_i = 10'(drv_addr); burstcount_i = 4'(bc);
        byteenable_i = be; writedata_i = d;
        for (int i = 0; i < 64; i++) begin
            #1;
            acc = (waitrequest_o === 1'b0);
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1 write_i = 0;
        chk("wr_accept", acc, 1);
        if (acc) begin
            for (int k = 0; k < 8; k++)
                if (be[k]) model[m_addr % 1024][k*8 +: 8] = d[k*8 +: 8];
        end
    endtask

    task automatic wr_burst(input int addr, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            wr((i == 0) ? addr : 7, (i == 0) ? n : 0, addr + i, 8'hFF, base + 64'(i));
            if (i == 0 && n > 1) chk("busy_wburst", busy_o, 1);
        end
    endtask

    task automatic rd(input int addr, input int bc, output int tacc);
        bit acc;
        int n, first;
        acc = 0; tacc = -1;
        @(negedge clk);
        read_i = 1; address_i = 10'(addr); burstcount_i = 4'(bc);
        for (int i = 0; i < 64; i++) begin
            #1;
            acc = (waitrequest_o === 1'b0);
            @(posedge clk);
            if (acc) begin tacc = edge_cnt; break; end
            @(negedge clk);
        end
        #1 read_i = 0;
        chk("rd_accept", acc, 1);
        if (acc) begin
            n = (bc == 0) ? 1 : bc;
            first = (tacc + LAT > last_edge + 1) ? tacc + LAT : last_edge + 1;
            for (int k = 0; k < n; k++) sb.push_back('{model[(addr + k) % 1024], first + k});
            last_edge = first + n - 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;
        rst_i = 1; read_i = 0; write_i = 0; address_i = '0; burstcount_i = '0;
        byteenable_i = '0; writedata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_waitreq", waitrequest_o, 1);
        chk("rst_rdvalid", readdatavalid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_perr", proto_err_o, 0);
        chk("rst_rdata", readdata_o, 0);
        rst_i = 0;
        #1 chk("post_rst_waitreq", waitrequest_o, 0);

        // 1: burst write then burst read with exact latency
        wr_burst(16'h10, 4, 64'd1);
        rd(16'h10, 4, t);
        drain();
        chk("busy_after_t1", busy_o, 0);

        // 2: byte-masked overwrite
        wr(5, 1, 5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(5, 1, 5, 8'h0F, 64'h0);
        rd(5, 1, t);
        drain();

        // 3: queue fills, fifth read stalls until the first slot frees
        rd(16'h10, 1, t1);
        rd(16'h11, 1, t2);
        rd(16'h12, 1, t3);
        rd(16'h13, 1, t4);
        rd(5, 1, t5);
        chk("q_acc2", t2, t1 + 1);
        chk("q_acc3", t3, t1 + 2);
        chk("q_acc4", t4, t1 + 3);
        chk("q_acc5_stall", t5, t1 + LAT + 1);
        drain();

        // 4: address wrap for write and read bursts
        wr_burst(1023, 2, 64'hAAAA_0000_0000_0000);
        rd(1023, 2, t);
        drain();
        chk("perr_clean", proto_err_o, 0);

        // 5: read/write collision and zero-count read
        @(negedge clk);
        read_i = 1; write_i = 1; address_i = 10'h11; burstcount_i = 4'd1;
        byteenable_i = 8'hFF; writedata_i = 64'hDEAD;
        #1 chk("collide_waitreq", waitrequest_o, 1);
        @(posedge clk);
        #1 begin read_i = 0; write_i = 0; end
        @(negedge clk);
        chk("perr_set", proto_err_o, 1);
        rd(16'h11, 0, t);
        drain();
        chk("perr_sticky", proto_err_o, 1);

        // 6: reset during second beat of an 8-beat read
        wr_burst(16'h20, 8, 64'h100);
        rd(16'h20, 8, t);
        while (edge_cnt < t + LAT + 2) @(negedge clk);
        #2;
        chk("beats_before_rst", sb.size(), 6);
        sb.delete();
        last_edge = -1000;
        rst_i = 1;
        @(negedge clk);
        chk("rst_mid_rdvalid", readdatavalid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_waitreq", waitrequest_o, 1);
        chk("rst_mid_rdata", readdata_o, 0);
        @(negedge clk);
        rst_i = 0;
        #1 chk("rel_waitreq", waitrequest_o, 0);
        chk("rel_perr", proto_err_o, 0);
        chk("rel_busy", busy_o, 0);
        repeat (12) @(negedge clk);
        rd(16'h20, 1, t);
        rd(16'h10, 1, t);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/amm_slave_responder.md
Name: amm_slave_responder

Overview:
Avalon-MM slave memory model that answers the memory checker's master traffic. It is the responder end of the bus that the measurement logic monitors.
- Accepts single and burst writes with byte masking.
- Queues up to RD_Q_DEPTH pipelined read bursts.
- Returns read data with a programmable fixed latency.
- Optionally injects pseudo-random waitrequest stalls.

Used as the on-chip target for checker self-test and for measurement-block verification.

Parameters:
ADDR_W, 10, word address width; memory depth 2**ADDR_W words
DATA_W, 64, data width in bits; byteenable width DATA_W/8
AMM_BURST_W, 4, burstcount width; max burst 2**(AMM_BURST_W-1)
RD_LATENCY, 4, cycles from read acceptance edge to first readdatavalid_o beat; legal 2..255
RD_Q_DEPTH, 4, outstanding read command slots; power of two

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
address_i  in  ADDR_W  word address, sampled on first beat or read command
read_i  in  1  read request
write_i  in  1  write request
burstcount_i  in  AMM_BURST_W  beats per burst, sampled with address_i
byteenable_i  in  DATA_W/8  byte mask per write beat
writedata_i  in  DATA_W  write data
waitrequest_o  out  1  stall; transfer accepted only when low
readdata_o  out  DATA_W  read beat data
readdatavalid_o  out  1  read beat strobe
busy_o  out  1  read queue non-empty, read burst active, or write burst incomplete
proto_err_o  out  1  sticky protocol violation flag

Interface:
- One clock; reset is synchronous and active-high.
- Clock port clk_i, reset port rst_i.

Behaviour:
- Reset (rst_i high at edge): queue empty, write burst idle, readdatavalid_o=0, busy_o=0, proto_err_o=0, readdata_o=0.
- waitrequest_o=1 while rst_i high. Memory contents are not reset.
- waitrequest_o is combinational. It is high when any of:
  - rst_i;
  - read_i and queue full;
  - read_i and a write burst is incomplete;
  - read_i and write_i together;
  - injected stall (optional feature).
- Write FSM, states W_IDLE and W_BURST:
  - In W_IDLE, an accepted write latches the address and the beat count and writes beat 0 to address_i.
  - If burstcount_i > 1, go to W_BURST.
  - In W_BURST, each accepted beat writes to base+n, n=1..count-1. address_i and burstcount_i are ignored on these beats.
  - Return to W_IDLE after the last beat. Cycles with write_i low are idle, with no timeout.
- Byte k of a word is updated only if byteenable_i[k]=1.
- The write takes effect at the accepting edge. A read beat emitted in any later cycle sees the new data.
- Read acceptance: read_i && !waitrequest_o pushes {address, burstcount, stamp} into the queue. stamp is a free-running 16-bit cycle counter; comparison uses modulo subtraction.
- Read emission FSM, states R_IDLE and R_BURST:
  - The head entry is eligible when (now-stamp) >= RD_LATENCY-1. The first beat then appears in the cycle after edge T+RD_LATENCY, where T is the accepting edge.
  - Beats are emitted on consecutive cycles, address incrementing by 1, with readdatavalid_o=1.
  - The next entry starts in the cycle after the last beat, or later if its latency has not yet elapsed. There are no gaps inside a burst and no overlap between bursts.
  - The queue pop happens on the last beat, so a full queue frees a slot at that edge.
- Address arithmetic wraps modulo 2**ADDR_W.
- burstcount_i=0 on read or first write beat: treated as 1 and sets proto_err_o.
- read_i and write_i high together: nothing is accepted, waitrequest_o=1, proto_err_o set.
- proto_err_o clears only on reset.
- A read and a write beat accepted in different cycles of an overlapping period are independent. Read data emission continues while a write burst is in progress.
- Reset mid-burst: all in-flight reads are dropped, readdatavalid_o falls at that edge, and a partial write burst is abandoned. Already-written words are kept.

Optional Feature:
- AMM_RESP_WAIT_INJECT_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - When lfsr[2:0]==3'b000, waitrequest_o is forced high for that cycle for both reads and writes. This gives roughly a 1/8 stall rate.
  - Latency counting is unaffected; it is measured from actual acceptance.
- Undefined: no LFSR, no injected stalls.

Test Plan:
1. Reset, write burst of 4 to addr 0x10 with data 1..4 and byteenable all-ones, then read burst 4 at 0x10 accepted at edge T -> readdatavalid_o high in the 4 cycles after edges T+4..T+7, data 1,2,3,4, busy_o low afterwards.
2. Write 0xFFFF_FFFF_FFFF_FFFF to addr 5, then write 0 with byteenable 8'h0F, then read addr 5 -> 0xFFFF_FFFF_0000_0000.
3. 5 back-to-back single reads with no injection -> first 4 accepted, 5th stalled until the first beat returns; 5 beats arrive in order.
4. Read burst 2 at addr 2**ADDR_W-1 -> beats from addresses 1023 and 0 (wrap).
5. read_i and write_i asserted together, then burstcount 0 read -> proto_err_o=1 and sticky; the zero-count read returns exactly 1 beat.
6. Reset asserted during the 2nd beat of an 8-beat read -> readdatavalid_o=0 from the next cycle, queue empty, waitrequest_o low after reset release.
